// File: rtl/alu_pkg.sv
// Shared ALU types and default sizes for the ALU and its request issuer.
package alu_pkg;

  localparam int unsigned WIDTH_D   = 8;
  localparam int unsigned TAG_W_D   = 4;
  localparam int unsigned DEPTH_D   = 4;
  localparam int unsigned ALU_LAT_D = 2;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } operation_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage and occupancy count.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/alu_req_issuer.sv
// Credit-based issuer for a fixed-latency ALU with in-order tagged responses.
// Optional checker enabled by defining ALU_ISSUER_CHK_EN.
module alu_req_issuer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_D,
  parameter int unsigned TAG_W   = TAG_W_D,
  parameter int unsigned DEPTH   = DEPTH_D,
  parameter int unsigned ALU_LAT = ALU_LAT_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  operation_t       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output operation_t       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_valid,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_res_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             flush_req,
  output logic             flush_done,
  output logic             err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned RW = TAG_W + WIDTH;
`ifdef ALU_ISSUER_CHK_EN
  localparam int unsigned TS_W = $clog2(ALU_LAT + 4) + 1;
  localparam int unsigned QW   = TAG_W + TS_W;
`else
  localparam int unsigned QW   = TAG_W;
`endif

  issuer_state_t    r_state;
  logic             r_flush_done;
  logic             r_alu_valid;
  operation_t       r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;

  logic [QW-1:0]    w_tq_wdata;
  logic [QW-1:0]    w_tq_rdata;
  logic             w_tq_full;
  logic             w_tq_empty;
  logic [CW-1:0]    w_inflight;
  logic [RW-1:0]    w_rb_rdata;
  logic             w_rb_full;
  logic             w_rb_empty;
  logic [CW-1:0]    w_rsp_count;
  logic [CW-1:0]    w_credits;
  logic             w_accept;
  logic             w_res_wr;
  logic             w_rsp_pop;

`ifdef ALU_ISSUER_CHK_EN
  logic [TS_W-1:0] r_tick;
  logic [TS_W-1:0] w_age;
  logic            r_err;

  // Tag queue entries carry the cycle their op was presented to the ALU
  assign w_tq_wdata = {cmd_tag, r_tick + TS_W'(1)};
  assign w_age      = r_tick - w_tq_rdata[TS_W-1:0];
  assign err        = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick <= '0;
      r_err  <= 1'b0;
    end else begin
      r_tick <= r_tick + TS_W'(1);
      if (alu_res_valid && w_inflight == '0) begin
        r_err <= 1'b1;
      end
      if (!w_tq_empty && !alu_res_valid &&
          w_age > TS_W'(ALU_LAT + 2)) begin
        r_err <= 1'b1;
      end
    end
  end
`else
  assign w_tq_wdata = cmd_tag;
  assign err        = 1'b0;
`endif

  // Every accepted op reserves a buffer slot until its response leaves
  assign w_credits = CW'(DEPTH) - w_inflight - w_rsp_count;
  assign cmd_ready = (r_state == ST_RUN) && (w_credits != '0) &&
                     !w_tq_full;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_res_wr  = alu_res_valid && !w_tq_empty && !w_rb_full;
  assign w_rsp_pop = rsp_valid && rsp_ready;

  sync_fifo #(
    .W     (QW),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .wdata (w_tq_wdata),
    .pop   (w_res_wr),
    .rdata (w_tq_rdata),
    .full  (w_tq_full),
    .empty (w_tq_empty),
    .count (w_inflight)
  );

  sync_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_rsp_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (w_res_wr),
    .wdata ({w_tq_rdata[QW-1 -: TAG_W], alu_res}),
    .pop   (w_rsp_pop),
    .rdata (w_rb_rdata),
    .full  (w_rb_full),
    .empty (w_rb_empty),
    .count (w_rsp_count)
  );

  assign rsp_valid           = !w_rb_empty;
  assign {rsp_tag, rsp_data} = w_rb_rdata;

  assign alu_valid = r_alu_valid;
  assign alu_op    = r_alu_op;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_valid <= 1'b0;
      r_alu_op    <= OP_NOP;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
    end else begin
      r_alu_valid <= w_accept;
      if (w_accept) begin
        r_alu_op <= cmd_op;
        r_alu_a  <= cmd_a;
        r_alu_b  <= cmd_b;
      end
    end
  end

  assign flush_done = r_flush_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      unique case (r_state)
        ST_RUN: begin
          if (flush_req) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_inflight == '0 && w_rsp_count == '0) begin
            r_state      <= ST_DONE;
            r_flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_issuer.sv
// Self-checking bench for alu_req_issuer with a behavioural ALU and scoreboard.
module tb_alu_req_issuer;
  import alu_pkg::*;

  localparam int WIDTH   = 8;
  localparam int TAG_W   = 4;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid;
  logic             cmd_ready;
  operation_t       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  operation_t       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_valid;
  logic [WIDTH-1:0] alu_res;
  logic             alu_res_valid;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             flush_req;
  logic             flush_done;
  logic             err;
  logic             inj = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_req_issuer #(
    .WIDTH   (WIDTH),
    .TAG_W   (TAG_W),
    .DEPTH   (DEPTH),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_tag       (cmd_tag),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_valid     (alu_valid),
    .alu_res       (alu_res),
    .alu_res_valid (alu_res_valid),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_tag       (rsp_tag),
    .flush_req     (flush_req),
    .flush_done    (flush_done),
    .err           (err)
  );

  function automatic logic [WIDTH-1:0] calc(operation_t op,
                                            logic [WIDTH-1:0] a,
                                            logic [WIDTH-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic void chk(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fixed-latency ALU sharing the issuer reset
  logic [WIDTH-1:0]   p_res [ALU_LAT];
  logic [ALU_LAT-1:0] p_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_v <= '0;
      for (int i = 0; i < ALU_LAT; i++) p_res[i] <= '0;
    end else begin
      p_v      <= {p_v[ALU_LAT-2:0], alu_valid};
      p_res[0] <= calc(alu_op, alu_a, alu_b);
      for (int i = 1; i < ALU_LAT; i++) p_res[i] <= p_res[i-1];
    end
  end

  assign alu_res_valid = p_v[ALU_LAT-1] | inj;
  assign alu_res       = p_res[ALU_LAT-1];

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             exp_q[$];
  int               n_acc = 0;
  int               n_rsp = 0;
  bit               hold_pend = 0;
  logic [TAG_W-1:0] hold_t;
  logic [WIDTH-1:0] hold_d;

  // Scoreboard: in-order expectations, hold-stability, outstanding bound
  always @(negedge clk) begin
    int   occ;
    exp_t e;
    if (rst) begin
      exp_q.delete();
      n_acc     = 0;
      n_rsp     = 0;
      hold_pend = 0;
    end else begin
      occ = n_acc - n_rsp;
      if (hold_pend)
        chk("rsp_hold", {rsp_valid, rsp_tag, rsp_data}, {1'b1, hold_t, hold_d});
      hold_pend = rsp_valid && !rsp_ready;
      hold_t    = rsp_tag;
      hold_d    = rsp_data;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_tag", rsp_tag, e.tag);
          chk("rsp_data", rsp_data, e.data);
        end
        n_rsp++;
      end
      if (cmd_valid && cmd_ready) begin
        chk("credit_bound", occ < DEPTH, 1);
        e.tag  = cmd_tag;
        e.data = calc(cmd_op, cmd_a, cmd_b);
        exp_q.push_back(e);
        n_acc++;
      end
    end
  end

  typedef struct {
    operation_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] exp;
  } vec_t;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[6];
    int   lat, acc, base, first4, done_at, sent;
    bit   got, ok_block, seen_v, adv;

    tv[0] = '{OP_ADD, 8'd5,   8'd3,   4'h7, 8'd8};
    tv[1] = '{OP_SUB, 8'd3,   8'd5,   4'h2, 8'hFE};
    tv[2] = '{OP_NOP, 8'd1,   8'd1,   4'h9, 8'h00};
    tv[3] = '{OP_ADD, 8'hFF,  8'h01,  4'hF, 8'h00};
    tv[4] = '{OP_SUB, 8'h00,  8'h01,  4'h1, 8'hFF};
    tv[5] = '{OP_ADD, 8'h80,  8'h7F,  4'h4, 8'hFF};

    cmd_valid = 0; cmd_op = OP_NOP; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 0; flush_req = 0;

    #3;
    chk("rst_alu_valid",  alu_valid, 0);
    chk("rst_alu_op",     alu_op, OP_NOP);
    chk("rst_alu_a",      alu_a, 0);
    chk("rst_alu_b",      alu_b, 0);
    chk("rst_rsp_valid",  rsp_valid, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_err",        err, 0);
    chk("rst_cmd_ready",  cmd_ready, 1);
    @(posedge clk);
    #1 rst = 0;
    tick();

    // Single-op latency and arithmetic table
    rsp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1; cmd_op = tv[i].op; cmd_a = tv[i].a;
      cmd_b = tv[i].b; cmd_tag = tv[i].tag;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), cmd_ready, 1);
      tick();
      cmd_valid = 0;
      lat = 0; got = 0;
      while (!got && lat < 10) begin
        @(negedge clk);
        lat++;
        if (lat == 1)
          chk($sformatf("vec%0d_alu", i), {alu_valid, alu_op, alu_a, alu_b},
              {1'b1, tv[i].op, tv[i].a, tv[i].b});
        if (rsp_valid) got = 1;
      end
      chk($sformatf("vec%0d_lat", i), lat, 4);
      chk($sformatf("vec%0d_data", i), rsp_data, tv[i].exp);
      chk($sformatf("vec%0d_tag", i), rsp_tag, tv[i].tag);
      tick();
    end

    // Backpressure: only DEPTH accepts while responses are stalled
    rsp_ready = 0; acc = 0; first4 = 0; base = n_rsp;
    for (int cyc = 0; cyc < 12; cyc++) begin
      cmd_valid = (acc < 10); cmd_op = OP_ADD;
      cmd_a = 8'(acc); cmd_b = 8'd1; cmd_tag = 4'(acc);
      @(negedge clk);
      if (cmd_valid && cmd_ready) acc++;
      if (cyc == 3) first4 = acc;
      tick();
    end
    chk("bp_b2b", first4, 4);
    chk("bp_accepted", acc, 4);
    @(negedge clk);
    chk("bp_ready_low", cmd_ready, 0);
    tick();
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_head", {rsp_valid, rsp_tag}, {1'b1, 4'h0});
    if (cmd_valid && cmd_ready) acc++;
    tick();
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (acc == 10 && n_rsp - base == 10) break;
      cmd_valid = (acc < 10); cmd_op = OP_ADD;
      cmd_a = 8'(acc); cmd_b = 8'd1; cmd_tag = 4'(acc);
      @(negedge clk);
      if (cmd_valid && cmd_ready) acc++;
      tick();
    end
    cmd_valid = 0;
    chk("bp_resume", acc, 10);
    chk("bp_rsp", n_rsp - base, 10);

    // Random stream of 16 tagged commands with random response stalls
    sent = 0; base = n_rsp;
    cmd_op = operation_t'($urandom_range(0, 2));
    cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_tag = 4'(sent);
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (sent == 16 && n_rsp - base == 16) break;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cmd_valid = (sent < 16) && ($urandom_range(0, 3) != 0);
      @(negedge clk);
      adv = cmd_valid && cmd_ready;
      tick();
      if (adv) begin
        sent++;
        cmd_op = operation_t'($urandom_range(0, 2));
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_tag = 4'(sent);
      end
    end
    cmd_valid = 0; rsp_ready = 1;
    chk("rand_sent", sent, 16);
    chk("rand_rsp", n_rsp - base, 16);
    chk("rand_q_empty", exp_q.size(), 0);
    tick();

    // Flush with one buffered response and two ops in flight
    rsp_ready = 0; base = n_rsp;
    cmd_valid = 1; cmd_op = OP_ADD; cmd_a = 8'd10; cmd_b = 8'd20; cmd_tag = 4'hA;
    @(negedge clk);
    chk("fl_ready_a", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    chk("fl_buf_a", rsp_valid, 1);
    cmd_valid = 1; cmd_op = OP_SUB; cmd_a = 8'd7; cmd_b = 8'd9; cmd_tag = 4'hB;
    tick();
    cmd_op = OP_ADD; cmd_a = 8'd1; cmd_b = 8'd2; cmd_tag = 4'hC;
    tick();
    cmd_valid = 0; flush_req = 1;
    tick();
    flush_req = 0;
    cmd_valid = 1; cmd_op = OP_ADD; cmd_a = 8'd4; cmd_b = 8'd4; cmd_tag = 4'hD;
    ok_block = 1; done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (i == 6) rsp_ready = 1;
      @(negedge clk);
      if (flush_done) begin
        done_at = i;
        break;
      end
      if (cmd_ready) ok_block = 0;
      tick();
    end
    chk("fl_blocked", ok_block, 1);
    chk("fl_done_seen", done_at >= 0, 1);
    chk("fl_consumed", n_rsp - base, 3);
    chk("fl_ready_done", cmd_ready, 0);
    tick();
    @(negedge clk);
    chk("fl_pulse_1cyc", flush_done, 0);
    chk("fl_ready_back", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    for (int i = 0; i < 20 && n_rsp - base < 4; i++) tick();
    chk("fl_d_rsp", n_rsp - base, 4);

    // Asynchronous reset with three ops in flight
    rsp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1; cmd_op = OP_ADD;
      cmd_a = 8'(k); cmd_b = 8'd3; cmd_tag = 4'(k);
      tick();
    end
    cmd_valid = 0;
    #1 rst = 1;
    #1;
    chk("mrst_alu_valid", alu_valid, 0);
    chk("mrst_alu", {alu_op, alu_a, alu_b}, 0);
    chk("mrst_rsp_valid", rsp_valid, 0);
    chk("mrst_flush_done", flush_done, 0);
    @(posedge clk);
    #1 rst = 0;
    seen_v = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) seen_v = 1;
      tick();
    end
    chk("mrst_no_rsp", seen_v, 0);
    chk("mrst_ready", cmd_ready, 1);

`ifdef ALU_ISSUER_CHK_EN
    chk("err_clear", err, 0);
    inj = 1;
    tick();
    inj = 0;
    @(negedge clk);
    chk("err_set", err, 1);
    repeat (5) tick();
    chk("err_sticky", err, 1);
`else
    chk("err_tied", err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
